// File: rtl/i2s_rx_deser_if.sv
// I2S receiver bus: codec pins into the deserializer and the parallel sample pair out.
interface i2s_rx_deser_if #(
  parameter int DATA_W = 16
);
  logic              BCLK;
  logic              LRCLK;
  logic              SDout;
  logic              aud_vld;
  logic [DATA_W-1:0] lft_aud;
  logic [DATA_W-1:0] rht_aud;
  logic              frm_err;

  modport master (
    output BCLK, LRCLK, SDout,
    input  aud_vld, lft_aud, rht_aud, frm_err
  );

  modport slave (
    input  BCLK, LRCLK, SDout,
    output aud_vld, lft_aud, rht_aud, frm_err
  );
endinterface

// File: rtl/i2s_rx_deser.sv
// I2S deserializer: synchronizes the codec pins to clk and emits signed left/right
// sample pairs with a one-cycle aud_vld strobe; short slots raise frm_err.
module i2s_rx_deser #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  i2s_rx_deser_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {WAIT_SYNC, SKIP, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_reg, lrclk_sync_reg, sdout_sync_reg;
  logic                   bclk_prev_reg, lr_prev_reg;
  logic                   rise_reg, sd_reg, lr_rise_reg, lr_fall_reg;
  logic                   bclk_s, lr_s, sd_s, bclk_rise;

  state_t                 state_reg;
  logic                   chan_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [DATA_W-2:0]      shift_reg;
  logic [DATA_W-1:0]      lft_hold_reg, rht_hold_reg;
  logic                   lft_ok_reg, pair_rdy_reg;
  logic                   aud_vld_reg, frm_err_reg;
  logic [DATA_W-1:0]      lft_aud_reg, rht_aud_reg;

  logic [CNT_W-1:0]       cnt_next;
  logic [DATA_W-1:0]      word_next;
  logic                   lr_edge;

  assign bclk_s    = bclk_sync_reg[SYNC_STAGES-1];
  assign lr_s      = lrclk_sync_reg[SYNC_STAGES-1];
  assign sd_s      = sdout_sync_reg[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_reg;

  assign cnt_next  = bit_cnt_reg + 1'b1;
  assign word_next = {shift_reg, sd_reg};
  assign lr_edge   = lr_rise_reg | lr_fall_reg;

  // Pin synchronizers plus one register of BCLK-rise events feeding the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_reg  <= '0;
      lrclk_sync_reg <= '0;
      sdout_sync_reg <= '0;
      bclk_prev_reg  <= 1'b0;
      lr_prev_reg    <= 1'b0;
      rise_reg       <= 1'b0;
      sd_reg         <= 1'b0;
      lr_rise_reg    <= 1'b0;
      lr_fall_reg    <= 1'b0;
    end else begin
      bclk_sync_reg  <= {bclk_sync_reg[SYNC_STAGES-2:0], bus.BCLK};
      lrclk_sync_reg <= {lrclk_sync_reg[SYNC_STAGES-2:0], bus.LRCLK};
      sdout_sync_reg <= {sdout_sync_reg[SYNC_STAGES-2:0], bus.SDout};
      bclk_prev_reg  <= bclk_s;
      if (bclk_rise) begin
        lr_prev_reg <= lr_s;
      end
      rise_reg    <= bclk_rise;
      sd_reg      <= sd_s;
      lr_rise_reg <= bclk_rise & lr_s & ~lr_prev_reg;
      lr_fall_reg <= bclk_rise & ~lr_s & lr_prev_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WAIT_SYNC;
      chan_reg     <= 1'b0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      lft_hold_reg <= '0;
      rht_hold_reg <= '0;
      lft_ok_reg   <= 1'b0;
      pair_rdy_reg <= 1'b0;
      aud_vld_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
      lft_aud_reg  <= '0;
      rht_aud_reg  <= '0;
    end else begin
      aud_vld_reg  <= 1'b0;
      frm_err_reg  <= 1'b0;
      pair_rdy_reg <= 1'b0;
      if (pair_rdy_reg) begin
        lft_aud_reg <= lft_hold_reg;
        rht_aud_reg <= rht_hold_reg;
        aud_vld_reg <= 1'b1;
      end
      case (state_reg)
        WAIT_SYNC: begin
          if (rise_reg && lr_fall_reg) begin
            state_reg <= SKIP;
            chan_reg  <= 1'b0;
          end
        end
        SKIP: begin
          state_reg   <= SHIFT;
          bit_cnt_reg <= '0;
        end
        SHIFT: begin
          if (rise_reg) begin
            // With DATA_W-wide slots the LSB arrives on the same rise as the LR edge.
            shift_reg   <= word_next[DATA_W-2:0];
            bit_cnt_reg <= cnt_next;
            if (cnt_next == CNT_W'(DATA_W)) begin
              if (chan_reg) begin
                rht_hold_reg <= word_next;
                pair_rdy_reg <= lft_ok_reg;
                lft_ok_reg   <= 1'b0;
              end else begin
                lft_hold_reg <= word_next;
                lft_ok_reg   <= 1'b1;
              end
              state_reg <= DONE;
            end else if (lr_edge) begin
              frm_err_reg <= 1'b1;
              lft_ok_reg  <= 1'b0;
            end
            if (lr_edge) begin
              state_reg <= SKIP;
              chan_reg  <= lr_rise_reg;
            end
          end
        end
        DONE: begin
          if (rise_reg && lr_edge) begin
            state_reg <= SKIP;
            chan_reg  <= lr_rise_reg;
          end
        end
        default: state_reg <= WAIT_SYNC;
      endcase
    end
  end

  assign bus.aud_vld = aud_vld_reg;
  assign bus.frm_err = frm_err_reg;
  assign bus.lft_aud = lft_aud_reg;
  assign bus.rht_aud = rht_aud_reg;
endmodule
